dac_lvds_rx: RTL and testbench

DAC_LVDS_RX -- requirements
Module: dac_lvds_rx

---
 rtl/dac_lvds_rx.sv | 167 ++++++++++++++++
 tb/tb_dac_lvds_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dac_lvds_rx.sv
// DDR LVDS receiver for a two-channel DAC link: recovers channel pairs from
// IDDR rise/fall captures using the DCI framing bit, with lock tracking.
module dac_lvds_rx #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic               clkD,
    input  logic               rst_in,
    input  logic [15:0]        d_rise,
    input  logic [15:0]        d_fall,
    input  logic               dci_rise,
    input  logic               dci_fall,
    input  logic               clr_in,
    output logic signed [15:0] DAC0_out,
    output logic signed [15:0] DAC1_out,
    output logic               valid_out,
    output logic               locked_out,
    output logic               swap_out,
    output logic [15:0]        err_cnt_out
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] CL_BAD     = 2'd0;
    localparam logic [1:0] CL_NORMAL  = 2'd1;
    localparam logic [1:0] CL_SWAPPED = 2'd2;
    localparam logic [7:0] LOCK_C     = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C   = 8'(UNLOCK_CNT);

    function automatic logic [1:0] classify(input logic dr, input logic df);
        logic [1:0] cl;
        case ({dr, df})
            2'b10:   cl = CL_NORMAL;
            2'b01:   cl = CL_SWAPPED;
            default: cl = CL_BAD;
        endcase
        return cl;
    endfunction

    state_t      state_r;
    logic [7:0]  run_r;
    logic        swap_r;
    logic [15:0] r1_d_rise_r, r1_d_fall_r, r2_d_fall_r;
    logic        r1_dci_rise_r, r1_dci_fall_r, r2_dci_rise_r, r2_dci_fall_r;
    logic [1:0]  class_s, r2_class_s;
    logic        match_s, err_event_s;
    logic [7:0]  run_inc_s;

    // Input capture pipeline; r2 only keeps what swapped alignment needs.
    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            r1_d_rise_r   <= 16'd0;
            r1_d_fall_r   <= 16'd0;
            r1_dci_rise_r <= 1'b0;
            r1_dci_fall_r <= 1'b0;
            r2_d_fall_r   <= 16'd0;
            r2_dci_rise_r <= 1'b0;
            r2_dci_fall_r <= 1'b0;
        end else begin
            r1_d_rise_r   <= d_rise;
            r1_d_fall_r   <= d_fall;
            r1_dci_rise_r <= dci_rise;
            r1_dci_fall_r <= dci_fall;
            r2_d_fall_r   <= r1_d_fall_r;
            r2_dci_rise_r <= r1_dci_rise_r;
            r2_dci_fall_r <= r1_dci_fall_r;
        end
    end

    // Frame classification and match against the candidate alignment.
    always_comb begin
        class_s     = classify(r1_dci_rise_r, r1_dci_fall_r);
        r2_class_s  = classify(r2_dci_rise_r, r2_dci_fall_r);
        match_s     = (class_s == (swap_r ? CL_SWAPPED : CL_NORMAL));
        run_inc_s   = run_r + 8'd1;
        err_event_s = (state_r == ST_LOCKED) && !match_s;
    end

    // Lock FSM: locked_out and swap_out are registered alongside the state.
    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_SEARCH;
            run_r      <= 8'd0;
            swap_r     <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    if (class_s != CL_BAD) begin
                        swap_r  <= (class_s == CL_SWAPPED);
                        run_r   <= 8'd1;
                        state_r <= ST_VERIFY;
                    end else begin
                        run_r   <= 8'd0;
                    end
                end
                ST_VERIFY: begin
                    if (match_s && (run_inc_s == LOCK_C)) begin
                        run_r      <= 8'd0;
                        state_r    <= ST_LOCKED;
                        locked_out <= 1'b1;
                    end else if (match_s) begin
                        run_r   <= run_inc_s;
                    end else begin
                        run_r   <= 8'd0;
                        state_r <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        run_r <= 8'd0;
                    end else if (run_inc_s == UNLOCK_C) begin
                        run_r      <= 8'd0;
                        state_r    <= ST_SEARCH;
                        locked_out <= 1'b0;
                    end else begin
                        run_r <= run_inc_s;
                    end
                end
                default: begin
                    run_r      <= 8'd0;
                    state_r    <= ST_SEARCH;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

    assign swap_out = swap_r;

    // Saturating error counter; clear wins over a simultaneous error.
    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            err_cnt_out <= 16'd0;
        end else if (clr_in) begin
            err_cnt_out <= 16'd0;
        end else if (err_event_s && (err_cnt_out != 16'hFFFF)) begin
            err_cnt_out <= err_cnt_out + 16'd1;
        end else begin
            err_cnt_out <= err_cnt_out;
        end
    end

    // Output pair: swapped frames span r2 (fall) and r1 (rise).
    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            DAC0_out  <= 16'sd0;
            DAC1_out  <= 16'sd0;
            valid_out <= 1'b0;
        end else begin
            if (swap_r) begin
                DAC0_out <= $signed(r2_d_fall_r);
                DAC1_out <= $signed(r1_d_rise_r);
            end else begin
                DAC0_out <= $signed(r1_d_rise_r);
                DAC1_out <= $signed(r1_d_fall_r);
            end
            valid_out <= (state_r == ST_LOCKED) && match_s &&
                         (!swap_r || (r2_class_s == CL_SWAPPED));
        end
    end

endmodule

// File: tb/tb_dac_lvds_rx.sv
// Directed bench for dac_lvds_rx: lock/unlock, alignment, error counter, resets.
module tb_dac_lvds_rx;

    logic        clkD = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] d_rise = 16'd0;
    logic [15:0] d_fall = 16'd0;
    logic        dci_rise = 1'b0;
    logic        dci_fall = 1'b0;
    logic        clr_in = 1'b0;

    logic signed [15:0] dac0, dac1, s_dac0, s_dac1;
    logic        valid, locked, swap, s_valid, s_locked, s_swap;
    logic [15:0] err, s_err;

    int errors = 0;
    int checks = 0;

    dac_lvds_rx u_dut (
        .clkD(clkD), .rst_in(rst_in), .d_rise(d_rise), .d_fall(d_fall),
        .dci_rise(dci_rise), .dci_fall(dci_fall), .clr_in(clr_in),
        .DAC0_out(dac0), .DAC1_out(dac1), .valid_out(valid),
        .locked_out(locked), .swap_out(swap), .err_cnt_out(err)
    );

    dac_lvds_rx #(.LOCK_CNT(2), .UNLOCK_CNT(255)) u_sat (
        .clkD(clkD), .rst_in(rst_in), .d_rise(d_rise), .d_fall(d_fall),
        .dci_rise(dci_rise), .dci_fall(dci_fall), .clr_in(clr_in),
        .DAC0_out(s_dac0), .DAC1_out(s_dac1), .valid_out(s_valid),
        .locked_out(s_locked), .swap_out(s_swap), .err_cnt_out(s_err)
    );

    always #5 clkD = ~clkD;

    task automatic step(input int n);
        repeat (n) @(posedge clkD);
        #1;
    endtask

    task automatic drive(input logic [15:0] r, input logic [15:0] f,
                         input logic dr, input logic df);
        d_rise = r;
        d_fall = f;
        dci_rise = dr;
        dci_fall = df;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, {15'd0, locked}, 16'd0);
        chk({tag, "_valid"},  {15'd0, valid},  16'd0);
        chk({tag, "_swap"},   {15'd0, swap},   16'd0);
        chk({tag, "_err"},    err,             16'd0);
        chk({tag, "_dac0"},   dac0,            16'd0);
        chk({tag, "_dac1"},   dac1,            16'd0);
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
    endtask

    initial begin
        logic [15:0] k_prev, k_cur;

        // Power-on reset, before any clock edge.
        #3;
        chk_zero("por");
        step(2);
        rst_in = 1'b0;

        // Normal alignment lock.
        drive(16'h1234, 16'hABCD, 1'b1, 1'b0);
        step(16);
        chk("norm_locked_16", {15'd0, locked}, 16'd0);
        step(1);
        chk("norm_locked_17", {15'd0, locked}, 16'd1);
        chk("norm_swap", {15'd0, swap}, 16'd0);
        step(1);
        chk("norm_valid", {15'd0, valid}, 16'd1);
        chk("norm_dac0", dac0, 16'h1234);
        chk("norm_dac1", dac1, 16'hABCD);

        // Three bad frames keep lock, four consecutive drop it.
        drive(16'h1234, 16'hABCD, 1'b1, 1'b1);
        step(3);
        chk("bad3_valid_mid", {15'd0, valid}, 16'd0);
        drive(16'h1234, 16'hABCD, 1'b1, 1'b0);
        step(1);
        chk("bad3_valid_last", {15'd0, valid}, 16'd0);
        chk("bad3_locked", {15'd0, locked}, 16'd1);
        chk("bad3_err", err, 16'd3);
        step(1);
        chk("bad3_valid_back", {15'd0, valid}, 16'd1);
        drive(16'h1234, 16'hABCD, 1'b1, 1'b1);
        step(4);
        drive(16'h1234, 16'hABCD, 1'b1, 1'b0);
        step(1);
        chk("bad4_locked", {15'd0, locked}, 16'd0);
        chk("bad4_err", err, 16'd7);

        // Swapped stream: d_fall=k, next d_rise=k+8000.
        pulse_reset();
        k_prev = 16'h0100;
        for (int j = 1; j <= 20; j++) begin
            k_cur = 16'h0100 + 16'(j);
            drive(k_prev + 16'h8000, k_cur, 1'b0, 1'b1);
            step(1);
            if (j == 2)  chk("swp_swap", {15'd0, swap}, 16'd1);
            if (j == 16) chk("swp_locked_16", {15'd0, locked}, 16'd0);
            if (j == 17) chk("swp_locked_17", {15'd0, locked}, 16'd1);
            if (j >= 18) begin
                chk("swp_valid", {15'd0, valid}, 16'd1);
                chk("swp_dac0", dac0, 16'h0100 + 16'(j - 2));
                chk("swp_dac1", dac1, 16'h8100 + 16'(j - 2));
            end
            k_prev = k_cur;
        end

        // Partial normal run interrupted by a swapped frame restarts the count.
        pulse_reset();
        for (int j = 1; j <= 28; j++) begin
            if (j <= 10) drive(16'h1111, 16'h2222, 1'b1, 1'b0);
            else         drive(16'h3333, 16'h4444, 1'b0, 1'b1);
            step(1);
            if (j == 12) chk("rst_cnt_swap_12", {15'd0, swap}, 16'd0);
            if (j == 13) chk("rst_cnt_swap_13", {15'd0, swap}, 16'd1);
            if (j == 27) chk("rst_cnt_locked_27", {15'd0, locked}, 16'd0);
            if (j == 28) chk("rst_cnt_locked_28", {15'd0, locked}, 16'd1);
        end

        // Asynchronous reset between edges while locked.
        step(2);
        #2;
        rst_in = 1'b1;
        #1;
        chk_zero("async");
        step(1);
        #2;
        rst_in = 1'b0;
        drive(16'h5555, 16'h6666, 1'b1, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            step(1);
            chk("relock_wait", {15'd0, locked}, 16'd0);
        end
        step(1);
        chk("relock_done", {15'd0, locked}, 16'd1);

        // Error counter saturation and clear on the long-unlock instance.
        pulse_reset();
        drive(16'h0001, 16'h0002, 1'b1, 1'b0);
        step(3);
        chk("sat_locked", {15'd0, s_locked}, 16'd1);
        for (int g = 0; g < 258; g++) begin
            drive(16'h0001, 16'h0002, 1'b1, 1'b1);
            step(254);
            drive(16'h0001, 16'h0002, 1'b1, 1'b0);
            step(1);
        end
        chk("sat_fffc", s_err, 16'hFFFC);
        drive(16'h0001, 16'h0002, 1'b1, 1'b1);
        step(3);
        drive(16'h0001, 16'h0002, 1'b1, 1'b0);
        step(1);
        chk("sat_ffff", s_err, 16'hFFFF);
        chk("sat_still_locked", {15'd0, s_locked}, 16'd1);
        drive(16'h0001, 16'h0002, 1'b1, 1'b1);
        step(5);
        drive(16'h0001, 16'h0002, 1'b1, 1'b0);
        step(1);
        chk("sat_hold", s_err, 16'hFFFF);
        drive(16'h0001, 16'h0002, 1'b1, 1'b1);
        step(1);
        clr_in = 1'b1;
        step(1);
        clr_in = 1'b0;
        chk("sat_clr", s_err, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
